// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter fed by a 2**DEPTH_LOG2-entry FIFO.
// Frame: start, DATA_W bits LSB first, optional parity, 1 or 2 stop bits.
// Ports: clk, rstn (async, active low), enable, fill/tx_data (push),
//   parity (00 none, 01 even, 10 odd, 11 mark), stop2, div (clocks/bit,
//   0 and 1 act as 2), empty/full/level (registered FIFO status),
//   busy, overflow (sticky), tx (idle high, registered).
// Optional: define UART_TX_FIFO_CTS_EN to add cts_n (active-low flow
//   control, two-flop synchronised) gating the start of each frame.
module uart_tx_fifo #(
    parameter int DATA_W     = 8,
    parameter int DEPTH_LOG2 = 3,
    parameter int DIV_W      = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  enable,
`ifdef UART_TX_FIFO_CTS_EN
    input  logic                  cts_n,
`endif
    input  logic                  fill,
    input  logic [DATA_W-1:0]     tx_data,
    input  logic [1:0]            parity,
    input  logic                  stop2,
    input  logic [DIV_W-1:0]      div,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  busy,
    output logic                  overflow,
    output logic                  tx
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam int LVL_W = DEPTH_LOG2 + 1;
    localparam int BIT_W = $clog2(DATA_W + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
    } state_t;

    logic [DATA_W-1:0]     mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]      level_q, level_d;
    logic                  empty_q, full_q, ovf_q;

    state_t                state_q, state_d;
    logic [DIV_W-1:0]      cnt_q, cnt_d, div_q, div_d, div_clamp;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic [DATA_W-1:0]     shift_q, shift_d, head;
    logic [1:0]            par_q, par_d;
    logic                  parbit_q, parbit_d;
    logic                  stop2_q, stop2_d;
    logic                  tx_q, tx_d, busy_q, busy_d;
    logic                  push, pop, start_ok, bit_end, cts_ok;

`ifdef UART_TX_FIFO_CTS_EN
    logic cts_s1_q, cts_s2_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cts_s1_q <= 1'b1;
            cts_s2_q <= 1'b1;
        end else begin
            cts_s1_q <= cts_n;
            cts_s2_q <= cts_s1_q;
        end
    end

    assign cts_ok = !cts_s2_q;
`else
    assign cts_ok = 1'b1;
`endif

    assign head      = mem[rd_ptr_q];
    assign div_clamp = (div < DIV_W'(2)) ? DIV_W'(2) : div;
    assign start_ok  = enable && !empty_q && cts_ok;
    assign bit_end   = (cnt_q == '0);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        div_d    = div_q;
        par_d    = par_q;
        parbit_d = parbit_q;
        stop2_d  = stop2_q;
        pop      = 1'b0;

        if (state_q != S_IDLE) begin
            cnt_d = bit_end ? div_q - DIV_W'(1) : cnt_q - DIV_W'(1);
        end

        unique case (state_q)
            S_IDLE: begin
                if (start_ok) pop = 1'b1;
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    bit_d   = '0;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == BIT_W'(DATA_W - 1)) begin
                        state_d = (par_q != 2'b00) ? S_PARITY : S_STOP;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) state_d = S_STOP;
            end
            S_STOP: begin
                // bit_q counts stop bits; the last one may chain into a new frame
                if (bit_end) begin
                    if (stop2_q && bit_q == '0) bit_d = BIT_W'(1);
                    else if (start_ok)          pop   = 1'b1;
                    else                        state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Frame settings are sampled once, together with the head word
        if (pop) begin
            state_d = S_START;
            shift_d = head;
            div_d   = div_clamp;
            cnt_d   = div_clamp - DIV_W'(1);
            par_d   = parity;
            stop2_d = stop2;
            bit_d   = '0;
            unique case (parity)
                2'b01:   parbit_d = ^head;
                2'b10:   parbit_d = ~^head;
                default: parbit_d = 1'b1;
            endcase
        end
    end

    // tx follows the state one clock later, so the start bit begins on
    // the edge after the pop and every bit still lasts div_q clocks
    always_comb begin
        tx_d = 1'b1;
        unique case (state_q)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_q[0];
            S_PARITY: tx_d = parbit_q;
            default:  tx_d = 1'b1;
        endcase
    end

    // busy covers the lagged stop bit as well
    assign busy_d = (state_d != S_IDLE) || (state_q != S_IDLE);

    assign push    = fill && (!full_q || pop);
    assign level_d = level_q + LVL_W'(push) - LVL_W'(pop);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= tx_data;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            div_q    <= DIV_W'(2);
            par_q    <= 2'b00;
            parbit_q <= 1'b0;
            stop2_q  <= 1'b0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            div_q    <= div_d;
            par_q    <= par_d;
            parbit_q <= parbit_d;
            stop2_q  <= stop2_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
            if (push) wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
            level_q  <= level_d;
            empty_q  <= (level_d == '0);
            full_q   <= (level_d == LVL_W'(DEPTH));
            if (fill && !push) ovf_q <= 1'b1;
        end
    end

    assign empty    = empty_q;
    assign full     = full_q;
    assign level    = level_q;
    assign busy     = busy_q;
    assign overflow = ovf_q;
    assign tx       = tx_q;

endmodule
